// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response signal bundle.
// The master drives requests and response acceptance. The slave answers with acks and response beats.
interface sysbus_mem_responder_if #(
  parameter int TAG_W = 13
);
  logic             reqcyc;
  logic [63:0]      req;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic [TAG_W-1:0] resptag;
  logic             respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder. A read returns one line as eight 64-bit beats after a fixed latency.
// A write takes its eight data beats one cycle at a time, starting in the cycle after the address is sampled.
module sysbus_mem_responder #(
  parameter int LINE_WORDS = 8,
  parameter int LATENCY    = 4,
  parameter int MEM_WORDS  = 4096,
  parameter int TAG_W      = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  sysbus_mem_responder_if.slave bus
);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(LINE_WORDS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ZERO   = BEAT_W'(0);
  localparam logic [BEAT_W-1:0] BEAT_ONE    = BEAT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_START   = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]        TYPE_MEMORY = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_WDATA = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [BEAT_W-1:0] beat_r, beat_s;
  logic [IDX_W-1:0]  base_r, base_s;
  logic [TAG_W-1:0]  tag_r, tag_s;
  logic              is_mem_r, is_mem_s;

  logic              reqack_r, reqack_s;
  logic              respcyc_r, respcyc_s;
  logic [63:0]       resp_r, resp_s;
  logic [TAG_W-1:0]  resptag_r, resptag_s;

  logic [63:0]       mem_r [MEM_WORDS];
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_widx_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [63:0]       rd_data_s;
  logic [IDX_W-1:0]  req_base_s;
  logic [BEAT_W-1:0] beat_inc_s;

  // Line base: word index taken from the address with the beat bits cleared, wrapping modulo MEM_WORDS.
  assign req_base_s = {bus.req[3+IDX_W-1 : 3+BEAT_W], {BEAT_W{1'b0}}};
  assign beat_inc_s = beat_r + BEAT_ONE;

  // Read port address: the next beat while streaming, otherwise the first word of the line.
  always_comb begin
    rd_idx_s = base_r;
    if (state_r == ST_RESP) begin
      rd_idx_s = base_r | {{(IDX_W-BEAT_W){1'b0}}, beat_inc_s};
    end else begin
      rd_idx_s = base_r;
    end
  end

  assign rd_data_s  = mem_r[rd_idx_s];
  assign mem_widx_s = base_r | {{(IDX_W-BEAT_W){1'b0}}, beat_r};

  // Next-state and next-output logic for the request/response sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    beat_s    = beat_r;
    base_s    = base_r;
    tag_s     = tag_r;
    is_mem_s  = is_mem_r;
    reqack_s  = 1'b0;
    respcyc_s = 1'b0;
    resp_s    = resp_r;
    resptag_s = resptag_r;
    mem_we_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.reqcyc) begin
          base_s   = req_base_s;
          tag_s    = bus.reqtag;
          is_mem_s = (bus.reqtag[TAG_W-2 -: 4] == TYPE_MEMORY);
          reqack_s = 1'b1;
          beat_s   = BEAT_ZERO;
          if (bus.reqtag[TAG_W-1]) begin
            state_s = ST_WAIT;
            cnt_s   = CNT_START;
          end else begin
            state_s = ST_WDATA;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_s   = ST_RESP;
          beat_s    = BEAT_ZERO;
          respcyc_s = 1'b1;
          resp_s    = is_mem_r ? rd_data_s : 64'h0;
          resptag_s = tag_r;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      ST_RESP: begin
        // Without respack the presented beat stays on the bus unchanged.
        if (bus.respack) begin
          if (beat_r == LAST_BEAT) begin
            state_s   = ST_IDLE;
            beat_s    = BEAT_ZERO;
            respcyc_s = 1'b0;
          end else begin
            beat_s    = beat_inc_s;
            respcyc_s = 1'b1;
            resp_s    = is_mem_r ? rd_data_s : 64'h0;
          end
        end else begin
          respcyc_s = 1'b1;
        end
      end

      ST_WDATA: begin
        if (bus.reqcyc) begin
          reqack_s = 1'b1;
          mem_we_s = is_mem_r;
          if (beat_r == LAST_BEAT) begin
            state_s = ST_IDLE;
            beat_s  = BEAT_ZERO;
          end else begin
            beat_s = beat_inc_s;
          end
        end else begin
          beat_s = beat_r;
        end
      end

      default: begin
        state_s = ST_IDLE;
        beat_s  = BEAT_ZERO;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Sequencer state and registered bus outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      beat_r    <= BEAT_ZERO;
      base_r    <= {IDX_W{1'b0}};
      tag_r     <= {TAG_W{1'b0}};
      is_mem_r  <= 1'b0;
      reqack_r  <= 1'b0;
      respcyc_r <= 1'b0;
      resp_r    <= 64'h0;
      resptag_r <= {TAG_W{1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      beat_r    <= beat_s;
      base_r    <= base_s;
      tag_r     <= tag_s;
      is_mem_r  <= is_mem_s;
      reqack_r  <= reqack_s;
      respcyc_r <= respcyc_s;
      resp_r    <= resp_s;
      resptag_r <= resptag_s;
    end
  end

  // Backing store write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= bus.req;
    end else begin
      mem_r[mem_widx_s] <= mem_r[mem_widx_s];
    end
  end

  assign bus.reqack  = reqack_r;
  assign bus.respcyc = respcyc_r;
  assign bus.resp    = resp_r;
  assign bus.resptag = resptag_r;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: a line-level memory model predicts every read beat.
// A negedge monitor compares each presented beat against the queue.
module tb_sysbus_mem_responder;
  localparam int LATENCY   = 4;
  localparam int MEM_WORDS = 4096;
  localparam int TAG_W     = 13;
  localparam logic [3:0] T_MEM  = 4'b0001;
  localparam logic [3:0] T_MMIO = 4'b0010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sysbus_mem_responder_if #(.TAG_W(TAG_W)) bus ();

  sysbus_mem_responder #(
    .LINE_WORDS(8), .LATENCY(LATENCY), .MEM_WORDS(MEM_WORDS), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    int               beat;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model_mem [MEM_WORDS];
  logic [63:0] wdata [8];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int last_beat_cyc = 0;
  int burst_start = 0;
  int burst_span = 0;
  int stalls = 0;
  int ack_mode = 0;
  int hold_cnt = 0;
  logic prev_respcyc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int line_base(input logic [63:0] addr);
    return int'(((addr >> 3) % MEM_WORDS) / 8 * 8);
  endfunction

  always @(posedge clk) cyc++;

  // Response acceptance driver: always, random, or scripted stalls on beats 2 and 5.
  always @(posedge clk) begin
    #1;
    if (ack_mode == 0) bus.respack = 1'b1;
    else if (ack_mode == 1) bus.respack = ($urandom_range(0, 3) != 0);
    else begin
      if (bus.respcyc && sb_q.size() > 0 && (sb_q[0].beat == 2 || sb_q[0].beat == 5) && hold_cnt < 3) begin
        bus.respack = 1'b0;
        hold_cnt++;
      end else begin
        bus.respack = 1'b1;
        if (sb_q.size() == 0 || (sb_q[0].beat != 2 && sb_q[0].beat != 5)) hold_cnt = 0;
      end
    end
  end

  // Monitor: compares every presented beat with the scoreboard front, pops on acceptance.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.reqack) last_ack_cyc = cyc;
      if (bus.respcyc) begin
        if (!prev_respcyc) begin
          check("first beat latency", 64'(cyc - last_ack_cyc), 64'(LATENCY));
          burst_start = cyc;
          stalls = 0;
        end
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected beat: got resp %h with no read outstanding", bus.resp);
        end else begin
          check("resp data", bus.resp, sb_q[0].data);
          check("resptag", 64'(bus.resptag), 64'(sb_q[0].tag));
          if (bus.respack) begin
            if (sb_q[0].beat == 7) begin
              burst_span = cyc - burst_start + 1;
              last_beat_cyc = cyc;
              check("burst span", 64'(burst_span), 64'(8 + stalls));
            end
            void'(sb_q.pop_front());
          end else begin
            stalls++;
          end
        end
      end
      prev_respcyc = bus.respcyc;
    end else begin
      prev_respcyc = 1'b0;
    end
  end

  task automatic issue_read(input logic [63:0] addr, input logic [3:0] typ, input logic [7:0] id,
                            output int ack_cyc);
    int base;
    int n;
    exp_t e;
    base = line_base(addr);
    for (int i = 0; i < 8; i++) begin
      e.data = (typ == T_MEM) ? model_mem[base + i] : 64'h0;
      e.tag  = {1'b1, typ, id};
      e.beat = i;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.reqcyc = 1'b1;
    bus.req    = addr;
    bus.reqtag = {1'b1, typ, id};
    n = 0;
    ack_cyc = -1;
    while (n < 200 && ack_cyc < 0) begin
      @(posedge clk); #1;
      n++;
      if (bus.reqack) ack_cyc = cyc;
    end
    bus.reqcyc = 1'b0;
    if (ack_cyc < 0) begin
      checks++;
      $display("FAIL read ack timeout: no reqack for addr %h within 200 cycles", addr);
    end
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [3:0] typ, input logic [7:0] id,
                            input int gap_after);
    int base;
    base = line_base(addr);
    @(posedge clk); #1;
    bus.reqcyc = 1'b1;
    bus.req    = addr;
    bus.reqtag = {1'b0, typ, id};
    @(posedge clk); #1;
    check("write addr ack", 64'(bus.reqack), 64'h1);
    for (int i = 0; i < 8; i++) begin
      bus.req    = wdata[i];
      bus.reqcyc = 1'b1;
      @(posedge clk); #1;
      check("write beat ack", 64'(bus.reqack), 64'h1);
      if (typ == T_MEM) model_mem[base + i] = wdata[i];
      if (i == gap_after) begin
        bus.reqcyc = 1'b0;
        @(posedge clk); #1;
        check("write gap no ack", 64'(bus.reqack), 64'h0);
      end
    end
    bus.reqcyc = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.respcyc) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      $display("FAIL idle timeout: %0d beats still expected, required 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " reqack"}, 64'(bus.reqack), 64'h0);
    check({tag, " respcyc"}, 64'(bus.respcyc), 64'h0);
    check({tag, " resp"}, bus.resp, 64'h0);
    check({tag, " resptag"}, 64'(bus.resptag), 64'h0);
  endtask

  initial begin
    int ack_a;
    int ack_b;
    int n;
    logic [63:0] addr;
    bus.reqcyc  = 1'b0;
    bus.req     = 64'h0;
    bus.reqtag  = '0;
    bus.respack = 1'b1;
    reset = 1'b0;
    #1;
    check_outputs_zero("reset state");
    #21;
    reset = 1'b1;

    // Preload: mem[k] = k through ordinary write transactions.
    for (int l = 0; l < MEM_WORDS / 8; l++) begin
      for (int i = 0; i < 8; i++) wdata[i] = 64'(l * 8 + i);
      write_line(64'(l * 64), T_MEM, 8'h01, 8);
    end
    wait_idle();

    // Basic read with respack following respcyc.
    ack_mode = 0;
    issue_read(64'h1040, T_MEM, 8'h11, ack_a);
    wait_idle();
    check("basic read span", 64'(burst_span), 64'd8);

    // Backpressure: three-cycle stalls on beats 2 and 5.
    ack_mode = 2;
    issue_read(64'h1040, T_MEM, 8'h12, ack_a);
    wait_idle();
    check("backpressure span", 64'(burst_span), 64'd14);
    ack_mode = 0;

    // Write with a one-cycle gap after beat 3, then read it back.
    for (int i = 0; i < 8; i++) wdata[i] = 64'hA0 + 64'(i);
    write_line(64'h80, T_MEM, 8'h21, 3);
    repeat (3) @(posedge clk);
    issue_read(64'h80, T_MEM, 8'h22, ack_a);
    wait_idle();

    // Busy: a second read raised during RESP is acked only once IDLE is back.
    issue_read(64'h1040, T_MEM, 8'h31, ack_a);
    n = 0;
    while (!bus.respcyc && n < 50) begin @(posedge clk); #1; n++; end
    issue_read(64'h200, T_MEM, 8'h32, ack_b);
    check("busy ack timing", 64'(ack_b), 64'(last_beat_cyc + 2));
    wait_idle();

    // Wrap and non-memory type.
    issue_read(64'(MEM_WORDS * 8 + 'h40), T_MEM, 8'h41, ack_a);
    wait_idle();
    issue_read(64'h1040, T_MMIO, 8'h42, ack_a);
    wait_idle();
    for (int i = 0; i < 8; i++) wdata[i] = 64'hDEAD_0000 + 64'(i);
    write_line(64'h1040, T_MMIO, 8'h43, 8);
    issue_read(64'h1040, T_MEM, 8'h44, ack_a);
    wait_idle();

    // Reset during beat 3 of a read.
    issue_read(64'h40, T_MEM, 8'h51, ack_a);
    n = 0;
    while (!(bus.respcyc && sb_q.size() > 0 && sb_q[0].beat == 3) && n < 50) begin
      @(posedge clk); #2; n++;
    end
    reset = 1'b0;
    #1;
    check_outputs_zero("async reset");
    sb_q.delete();
    @(posedge clk); @(negedge clk); #1;
    reset = 1'b1;
    issue_read(64'h40, T_MEM, 8'h52, ack_a);
    wait_idle();

    // Randomized mix of reads and writes.
    for (int t = 0; t < 40; t++) begin
      addr = {$urandom, $urandom};
      ack_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 6) begin
        issue_read(addr, ($urandom_range(0, 6) != 0) ? T_MEM : T_MMIO, 8'($urandom), ack_a);
      end else begin
        for (int i = 0; i < 8; i++) wdata[i] = {$urandom, $urandom};
        write_line(addr, ($urandom_range(0, 6) != 0) ? T_MEM : T_MMIO, 8'($urandom),
                   $urandom_range(0, 8));
      end
      wait_idle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
